// File: rtl/gray_sync_decode.sv
// gray_sync_decode
//   Receiver-side stage for Gray-coded values (counter / FIFO pointers) that
//   arrive from another clock domain. The input passes through a flop-chain
//   synchronizer and is then decoded to binary. The block also reports the
//   step direction, flags multi-bit jumps and keeps a saturating error count.
//
// Parameters
//   WIDTH        code width in bits (>= 2)
//   SYNC_STAGES  synchronizer flop count (>= 2)
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   gray_in    in   WIDTH  Gray code, asynchronous to clk
//   bin_out    out  WIDTH  decoded binary of the last accepted sample
//   bin_valid  out  1      pipeline holds a real sample
//   changed    out  1      one-cycle pulse when bin_out takes a new value
//   dir_up     out  1      direction of the last legal step (1 = increment)
//   step_err   out  1      one-cycle pulse on a multi-bit jump
//   err_cnt    out  8      count of step_err pulses, saturating at 255
module gray_sync_decode #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             changed,
  output logic             dir_up,
  output logic             step_err,
  output logic [7:0]       err_cnt
);

  localparam int FILL_W = $clog2(SYNC_STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SYNC_STAGES);

  logic [WIDTH-1:0]  sync_p0 [SYNC_STAGES];
  logic [WIDTH-1:0]  gray_p1;
  logic [FILL_W-1:0] fill_cnt;

  logic [WIDTH-1:0]  new_gray;
  logic [WIDTH-1:0]  new_bin;
  logic [WIDTH-1:0]  bin_inc;
  logic [WIDTH-1:0]  diff;

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when more than one bit is set: clearing the lowest set bit leaves
  // something behind.
  function automatic logic multi_bit(input logic [WIDTH-1:0] d);
    return (d & (d - WIDTH'(1))) != '0;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign new_gray = sync_p0[SYNC_STAGES-1];
  assign new_bin  = gray_to_bin(new_gray);
  assign bin_inc  = bin_out + WIDTH'(1);
  assign diff     = new_gray ^ gray_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_p0[k] <= '0;
      end
      gray_p1   <= '0;
      fill_cnt  <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      changed   <= 1'b0;
      dir_up    <= 1'b1;
      step_err  <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      // Stage p0: synchronizer chain, last flop is the "new" sample.
      sync_p0[0] <= gray_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_p0[k] <= sync_p0[k-1];
      end

      // Stage p1: accepted sample, decoded output and status pulses.
      changed  <= 1'b0;
      step_err <= 1'b0;
      if (!bin_valid) begin
        // The chain only holds a real input once it has been refilled, so
        // the first accept carries no step information.
        if (fill_cnt == FILL_LAST) begin
          gray_p1   <= new_gray;
          bin_out   <= new_bin;
          bin_valid <= 1'b1;
        end else begin
          fill_cnt <= fill_cnt + 1'b1;
        end
      end else if (diff != '0) begin
        // Multi-bit jumps are still loaded so the block resynchronizes.
        gray_p1 <= new_gray;
        bin_out <= new_bin;
        changed <= 1'b1;
        if (multi_bit(diff)) begin
          step_err <= 1'b1;
          err_cnt  <= sat_inc(err_cnt);
        end else begin
          dir_up <= (new_bin == bin_inc);
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_sync_decode.sv
module tb_gray_sync_decode;
  localparam int W = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] gray_in = '0;
  logic [W-1:0] bin_out;
  logic         bin_valid;
  logic         changed;
  logic         dir_up;
  logic         step_err;
  logic [7:0]   err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int   dly[$];
  int   m_edges;
  bit   m_valid;
  int   m_bin;
  int   m_gray;
  bit   m_dir;
  bit   m_chg;
  bit   m_serr;
  int   m_err;

  always #5 clk = ~clk;

  gray_sync_decode #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .gray_in  (gray_in),
    .bin_out  (bin_out),
    .bin_valid(bin_valid),
    .changed  (changed),
    .dir_up   (dir_up),
    .step_err (step_err),
    .err_cnt  (err_cnt)
  );

  function automatic int g2b(int g);
    int b = 0;
    for (int k = 0; k < W; k++) b = b ^ (g >> k);
    return b & ((1 << W) - 1);
  endfunction

  function automatic int b2g(int b);
    return (b ^ (b >> 1)) & ((1 << W) - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Applies one clock edge to the model, using the inputs present at the edge.
  task automatic model_edge(input logic r, input int g);
    if (r) begin
      dly.delete();
      for (int k = 0; k < S; k++) dly.push_back(0);
      m_edges = 0; m_valid = 0; m_bin = 0; m_gray = 0;
      m_dir = 1; m_chg = 0; m_serr = 0; m_err = 0;
    end else begin
      int nw;
      int nb;
      nw = dly[S-1];
      dly.push_front(g);
      void'(dly.pop_back());
      m_chg = 0;
      m_serr = 0;
      if (!m_valid) begin
        m_edges++;
        if (m_edges == S + 1) begin
          m_valid = 1; m_gray = nw; m_bin = g2b(nw);
        end
      end else if (nw != m_gray) begin
        nb = g2b(nw);
        m_chg = 1;
        if ($countones(nw ^ m_gray) == 1) m_dir = (nb == (m_bin + 1) % (1 << W));
        else begin
          m_serr = 1;
          if (m_err < 255) m_err++;
        end
        m_gray = nw;
        m_bin = nb;
      end
    end
  endtask

  task automatic step(input logic r, input logic [W-1:0] g);
    rst = r;
    gray_in = g;
    @(posedge clk);
    model_edge(r, int'(g));
    #1;
    chk("bin_out", bin_out, m_bin);
    chk("bin_valid", bin_valid, m_valid);
    chk("changed", changed, m_chg);
    chk("dir_up", dir_up, m_dir);
    chk("step_err", step_err, m_serr);
    chk("err_cnt", err_cnt, m_err);
  endtask

  initial begin
    int b;
    int r;

    // 1: reset and fill with Gray 0111 (binary 5)
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0111);
    chk("rst_bin_out", bin_out, 0);
    chk("rst_dir_up", dir_up, 1);
    chk("rst_valid", bin_valid, 0);
    step(1'b0, 4'b0111);
    chk("fill1_valid", bin_valid, 0);
    step(1'b0, 4'b0111);
    chk("fill2_valid", bin_valid, 0);
    step(1'b0, 4'b0111);
    chk("fill3_valid", bin_valid, 1);
    chk("fill3_bin", bin_out, 4'b0101);
    chk("fill3_changed", changed, 0);
    chk("fill3_step_err", step_err, 0);

    // 2: walk down to 0, then count 0..15 and wrap to 0
    for (int v = 4; v >= 0; v--) step(1'b0, 4'(b2g(v)));
    for (int v = 1; v < 16; v++) step(1'b0, 4'(b2g(v)));
    step(1'b0, 4'b0000);
    for (int i = 0; i < 2; i++) step(1'b0, 4'b0000);
    chk("wrap_changed", changed, 1);
    chk("wrap_dir_up", dir_up, 1);
    chk("wrap_bin", bin_out, 0);
    step(1'b0, 4'b0000);
    chk("up_err_cnt", err_cnt, 0);

    // 3: down count through the wrap to 8, 7, 6
    for (int v = 15; v >= 6; v--) step(1'b0, 4'(b2g(v)));
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0101);
    chk("down_bin", bin_out, 6);
    chk("down_dir", dir_up, 0);
    chk("down_err_cnt", err_cnt, 0);

    // 4: illegal jump 0000 -> 0011
    for (int v = 5; v >= 0; v--) step(1'b0, 4'(b2g(v)));
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0000);
    step(1'b0, 4'b0011);
    step(1'b0, 4'b0011);
    step(1'b0, 4'b0011);
    chk("jump_step_err", step_err, 1);
    chk("jump_err_cnt", err_cnt, 1);
    chk("jump_bin", bin_out, 4'b0010);
    chk("jump_dir_kept", dir_up, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0010);
    chk("legal_after_jump_err", step_err, 0);
    chk("legal_after_jump_cnt", err_cnt, 1);

    // 5: saturation, then hold
    for (int i = 0; i < 300; i++) step(1'b0, (i % 2) ? 4'b0011 : 4'b0000);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 4'b0011);
      if (i >= 2) begin
        chk("hold_changed", changed, 0);
        chk("hold_step_err", step_err, 0);
      end
    end
    chk("sat_err_cnt", err_cnt, 255);

    // 6: reset mid-operation with err_cnt = 3
    step(1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0000);
    step(1'b0, 4'b0011);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0011);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0011);
    chk("mid_err_cnt3", err_cnt, 3);
    for (int v = 3; v <= 6; v++) step(1'b0, 4'(b2g(v)));
    step(1'b1, 4'(b2g(7)));
    chk("mid_rst_bin", bin_out, 0);
    chk("mid_rst_valid", bin_valid, 0);
    chk("mid_rst_changed", changed, 0);
    chk("mid_rst_dir", dir_up, 1);
    chk("mid_rst_step_err", step_err, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    step(1'b0, 4'(b2g(7)));
    chk("refill1_valid", bin_valid, 0);
    step(1'b0, 4'(b2g(7)));
    chk("refill2_valid", bin_valid, 0);
    step(1'b0, 4'(b2g(7)));
    chk("refill3_valid", bin_valid, 1);
    chk("refill3_bin", bin_out, 7);

    // 7: randomized legal steps, holds, jumps and occasional resets
    b = 7;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(99);
      if (r < 2) step(1'b1, 4'(b2g(b)));
      else if (r < 40) begin b = (b + 1) % 16; step(1'b0, 4'(b2g(b))); end
      else if (r < 75) begin b = (b + 15) % 16; step(1'b0, 4'(b2g(b))); end
      else if (r < 90) step(1'b0, 4'(b2g(b)));
      else begin b = $urandom_range(15); step(1'b0, 4'(b2g(b))); end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_sync_decode.md
# gray_sync_decode

Receiver-side stage for Gray-coded values, such as counter or FIFO pointers, produced by a binary-to-Gray encoder in another clock domain. The block synchronizes the Gray input through a flop chain and decodes it to binary. It also reports the step direction and flags illegal multi-bit jumps, keeping a saturating error count. It sits directly downstream of the binary-to-Gray converter and feeds binary consumers such as full/empty comparators.

## Interface
- `WIDTH`, default 4: code width in bits, at least 2.
- `SYNC_STAGES`, default 2: synchronizer flop count, at least 2.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `gray_in`  in  WIDTH: Gray code, asynchronous to `clk`.
- `bin_out`  out  WIDTH: decoded binary, registered.
- `bin_valid`  out  1: high once the pipeline holds a real sample.
- `changed`  out  1: one-cycle pulse when `bin_out` takes a new value.
- `dir_up`  out  1: direction of the last legal step; 1 = increment, 0 = decrement.
- `step_err`  out  1: one-cycle pulse when the new sample differs from the previous one in more than one bit.
- `err_cnt`  out  8: count of `step_err` pulses, saturating at 255.

## Operation
- **Sync chain:** `s[0] <= gray_in`, then `s[k] <= s[k-1]`. The last stage `s[SYNC_STAGES-1]` is the "new" sample.
- **Output register:** `gray_q` holds the last accepted Gray value. `bin_out` is the decoded form of `gray_q`:
  - `b[W-1] = g[W-1]`
  - `b[i] = b[i+1] ^ g[i]`
- **Fill counter:** counts edges after reset. The first sample is accepted on edge `SYNC_STAGES+1` after reset deassertion. On that edge:
  - `gray_q` is loaded.
  - `bin_valid` goes to 1.
  - `changed` and `step_err` stay 0, because there is no previous value to compare.
  - `bin_valid` then stays 1 until the next reset.
- **Each edge while `bin_valid` = 1:** let `d = new ^ gray_q`.
  - `d == 0`: hold all state; `changed` = 0, `step_err` = 0.
  - `popcount(d) == 1`: load `gray_q`; `changed` = 1. Set `dir_up` = 1 if new binary equals `bin_out + 1` mod 2^WIDTH, else `dir_up` = 0.
  - `popcount(d) > 1`: load `gray_q` so the block resynchronizes to the new value; `changed` = 1, `step_err` = 1. Increment `err_cnt` unless it is already 255. `dir_up` holds its value.
- **Wrap-around:** binary max to 0 (Gray `100..0` to `000..0`) is a legal increment, `dir_up` = 1. The reverse is a legal decrement, `dir_up` = 0.
- **Reset values:** all sync flops, `gray_q`, and the fill counter are 0. Outputs after reset: `bin_out` = 0, `bin_valid` = 0, `changed` = 0, `dir_up` = 1, `step_err` = 0, `err_cnt` = 0.
- **Reset mid-operation:** reset has priority over every other update. On the edge where `rst` = 1, all state returns to reset values. The fill sequence restarts after deassertion. `err_cnt` is cleared.

## Timing
- **Latency:** a change on `gray_in` that is stable before edge N appears on `bin_out` after edge `N+SYNC_STAGES`. `changed`, `step_err`, and `dir_up` update on that same edge.
- **Pulse registers:** `changed` and `step_err` are registered. They are high for exactly one cycle per accepted new value and are never high while `bin_valid` = 0.
- **Throughput:** one new value per cycle. Back-to-back legal steps on consecutive cycles give consecutive `changed` pulses.
- **Registered outputs:** all outputs are registered; there is no combinational path from `gray_in` to any output.
- **Metastability:** the input source must change at most one bit per source update. A bit caught mid-transition resolves to either the old or the new value, and both are legal. Multi-bit jumps are reported, not corrected.

## Test plan
Parameters for all scenarios: WIDTH = 4, SYNC_STAGES = 2.

1. **Reset and fill:** hold `rst` = 1 for 3 edges with `gray_in` = 0111. Release. Required:
   - `bin_valid` = 0 for 2 edges.
   - On the 3rd edge: `bin_valid` = 1 and `bin_out` = 0101, with `changed` = 0 and `step_err` = 0.
2. **Up count with wrap:** drive the Gray sequence for binary 0 to 15 and back to 0, one code per cycle. Required:
   - `bin_out` follows 0..15 then 0, lagging `gray_in` by 3 edges (2 sync + 1 output).
   - `changed` = 1 every cycle, `dir_up` = 1 throughout, including on 15 to 0 (Gray 1000 to 0000).
   - `step_err` = 0 and `err_cnt` = 0.
3. **Down count:** step Gray 1100 (binary 8), 0100 (7), 0101 (6). Required: `bin_out` shows 8, 7, 6 with `dir_up` = 0 after the first step and `step_err` never set.
4. **Illegal jump:** from Gray 0000, drive 0011 (two bits differ). Required:
   - `step_err` pulses once and `err_cnt` = 1.
   - `bin_out` = 0010 and `dir_up` keeps its prior value.
   - A following legal step gives `step_err` = 0.
5. **Saturation and hold:** force 300 illegal jumps, then hold `gray_in` constant for 10 cycles. Required:
   - `err_cnt` stops at 255.
   - During the hold, `changed` = 0 and `step_err` = 0.
6. **Reset mid-operation:** assert `rst` for one edge while counting up with `err_cnt` = 3. Required:
   - On that edge all outputs return to reset values, including `err_cnt` = 0.
   - `bin_valid` returns on the 3rd edge after deassertion.
